// File: rtl/i2c_target.sv
// I2C target: oversampled SCL/SDA, START/STOP detection, fixed 7-bit address
// match, write bytes bridged to an AXI-Stream master port, read bytes taken
// from an AXI-Stream slave port. SDA is open-drain via sda_oe_o; SCL is never
// stretched.
module i2c_target #(
    parameter logic [6:0] TARGET_ADDR = 7'h50
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe_o,
    output logic [7:0] m_axis_tdata_o,
    output logic       m_axis_tvalid_o,
    input  logic       m_axis_tready_i,
    output logic       m_axis_tuser_o,
    input  logic [7:0] s_axis_tdata_i,
    input  logic       s_axis_tvalid_i,
    output logic       s_axis_tready_o,
    output logic       busy_o,
    output logic       err_o
);

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_WR_DATA, S_WR_ACK, S_RD_DATA, S_RD_ACK, S_IGNORE
    } state_t;

    logic r_scl_s1, r_scl_s2, r_scl_d;
    logic r_sda_s1, r_sda_s2, r_sda_d;

    state_t     r_state, w_state_nxt;
    logic [3:0] r_bit_cnt, w_bit_cnt_nxt;
    logic [7:0] r_shift, w_shift_nxt;
    logic       r_rw, w_rw_nxt;
    logic       r_ack_drv, w_ack_drv_nxt;
    logic       r_first, w_first_nxt;
    logic       r_sda_oe, w_sda_oe_nxt;
    logic       r_busy, w_busy_nxt;
    logic       r_err, w_err_nxt;
    logic       r_s_tready, w_s_tready_nxt;
    logic [7:0] r_m_tdata, w_m_tdata_nxt;
    logic       r_m_tvalid, w_m_tvalid_nxt;
    logic       r_m_tuser, w_m_tuser_nxt;

    logic       w_scl_rise, w_scl_fall, w_start, w_stop;
    logic [7:0] w_byte, w_rd_byte;
    logic       w_out_free;

    assign w_scl_rise = r_scl_s2 & ~r_scl_d;
    assign w_scl_fall = ~r_scl_s2 & r_scl_d;
    assign w_start    = r_scl_s2 & r_scl_d & r_sda_d & ~r_sda_s2;
    assign w_stop     = r_scl_s2 & r_scl_d & ~r_sda_d & r_sda_s2;
    assign w_byte     = {r_shift[6:0], r_sda_s2};
    assign w_rd_byte  = s_axis_tvalid_i ? s_axis_tdata_i : 8'hFF;
    assign w_out_free = ~r_m_tvalid | m_axis_tready_i;

    // Two-flop synchronizers plus previous-value registers for edge detection.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_scl_s1 <= 1'b1; r_scl_s2 <= 1'b1; r_scl_d <= 1'b1;
            r_sda_s1 <= 1'b1; r_sda_s2 <= 1'b1; r_sda_d <= 1'b1;
        end else begin
            r_scl_s1 <= scl_i; r_scl_s2 <= r_scl_s1; r_scl_d <= r_scl_s2;
            r_sda_s1 <= sda_i; r_sda_s2 <= r_sda_s1; r_sda_d <= r_sda_s2;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= S_IDLE;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_rw       <= 1'b0;
            r_ack_drv  <= 1'b0;
            r_first    <= 1'b0;
            r_sda_oe   <= 1'b0;
            r_busy     <= 1'b0;
            r_err      <= 1'b0;
            r_s_tready <= 1'b0;
            r_m_tdata  <= '0;
            r_m_tvalid <= 1'b0;
            r_m_tuser  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_bit_cnt  <= w_bit_cnt_nxt;
            r_shift    <= w_shift_nxt;
            r_rw       <= w_rw_nxt;
            r_ack_drv  <= w_ack_drv_nxt;
            r_first    <= w_first_nxt;
            r_sda_oe   <= w_sda_oe_nxt;
            r_busy     <= w_busy_nxt;
            r_err      <= w_err_nxt;
            r_s_tready <= w_s_tready_nxt;
            r_m_tdata  <= w_m_tdata_nxt;
            r_m_tvalid <= w_m_tvalid_nxt;
            r_m_tuser  <= w_m_tuser_nxt;
        end
    end

    // Next-state and output logic; START/STOP override bit events.
    always_comb begin
        w_state_nxt    = r_state;
        w_bit_cnt_nxt  = r_bit_cnt;
        w_shift_nxt    = r_shift;
        w_rw_nxt       = r_rw;
        w_ack_drv_nxt  = r_ack_drv;
        w_first_nxt    = r_first;
        w_sda_oe_nxt   = r_sda_oe;
        w_busy_nxt     = r_busy;
        w_err_nxt      = 1'b0;
        w_s_tready_nxt = 1'b0;
        w_m_tdata_nxt  = r_m_tdata;
        w_m_tvalid_nxt = r_m_tvalid;
        w_m_tuser_nxt  = r_m_tuser;

        if (r_m_tvalid && m_axis_tready_i) w_m_tvalid_nxt = 1'b0;

        if (w_stop) begin
            w_state_nxt  = S_IDLE;
            w_sda_oe_nxt = 1'b0;
            w_busy_nxt   = 1'b0;
        end else if (w_start) begin
            w_state_nxt   = S_ADDR;
            w_bit_cnt_nxt = '0;
            w_sda_oe_nxt  = 1'b0;
        end else begin
            case (r_state)
                S_IDLE: ;
                S_ADDR: if (w_scl_rise) begin
                    w_shift_nxt = w_byte;
                    if (r_bit_cnt == 4'd7) begin
                        w_bit_cnt_nxt = '0;
                        if (w_byte[7:1] == TARGET_ADDR) begin
                            w_rw_nxt      = w_byte[0];
                            w_state_nxt   = S_ADDR_ACK;
                            w_ack_drv_nxt = 1'b0;
                            w_busy_nxt    = 1'b1;
                            w_first_nxt   = 1'b1;
                        end else begin
                            w_state_nxt = S_IGNORE;
                            w_busy_nxt  = 1'b0;
                        end
                    end else begin
                        w_bit_cnt_nxt = r_bit_cnt + 4'd1;
                    end
                end
                S_ADDR_ACK, S_WR_ACK: if (w_scl_fall) begin
                    if (!r_ack_drv) begin
                        w_sda_oe_nxt  = 1'b1;
                        w_ack_drv_nxt = 1'b1;
                    end else if (r_state == S_WR_ACK || !r_rw) begin
                        w_sda_oe_nxt  = 1'b0;
                        w_state_nxt   = S_WR_DATA;
                        w_bit_cnt_nxt = '0;
                    end else begin
                        // The fall ending the address ACK is also the read-byte load point.
                        w_shift_nxt    = w_rd_byte;
                        w_sda_oe_nxt   = ~w_rd_byte[7];
                        w_s_tready_nxt = s_axis_tvalid_i;
                        w_err_nxt      = ~s_axis_tvalid_i;
                        w_bit_cnt_nxt  = 4'd1;
                        w_state_nxt    = S_RD_DATA;
                    end
                end
                S_WR_DATA: if (w_scl_rise) begin
                    w_shift_nxt = w_byte;
                    if (r_bit_cnt == 4'd7) begin
                        w_bit_cnt_nxt = '0;
                        if (w_out_free) begin
                            w_m_tdata_nxt  = w_byte;
                            w_m_tvalid_nxt = 1'b1;
                            w_m_tuser_nxt  = r_first;
                            w_first_nxt    = 1'b0;
                            w_ack_drv_nxt  = 1'b0;
                            w_state_nxt    = S_WR_ACK;
                        end else begin
                            w_err_nxt   = 1'b1;
                            w_state_nxt = S_IGNORE;
                            w_busy_nxt  = 1'b0;
                        end
                    end else begin
                        w_bit_cnt_nxt = r_bit_cnt + 4'd1;
                    end
                end
                S_RD_DATA: if (w_scl_fall) begin
                    if (r_bit_cnt == 4'd0) begin
                        w_shift_nxt    = w_rd_byte;
                        w_sda_oe_nxt   = ~w_rd_byte[7];
                        w_s_tready_nxt = s_axis_tvalid_i;
                        w_err_nxt      = ~s_axis_tvalid_i;
                        w_bit_cnt_nxt  = 4'd1;
                    end else if (r_bit_cnt < 4'd8) begin
                        w_shift_nxt   = {r_shift[6:0], 1'b0};
                        w_sda_oe_nxt  = ~r_shift[6];
                        w_bit_cnt_nxt = r_bit_cnt + 4'd1;
                    end else begin
                        w_sda_oe_nxt = 1'b0;
                        w_state_nxt  = S_RD_ACK;
                    end
                end
                S_RD_ACK: if (w_scl_rise) begin
                    if (!r_sda_s2) begin
                        w_state_nxt   = S_RD_DATA;
                        w_bit_cnt_nxt = '0;
                    end else begin
                        w_state_nxt = S_IGNORE;
                        w_busy_nxt  = 1'b0;
                    end
                end
                S_IGNORE: w_sda_oe_nxt = 1'b0;
                default: begin
                    w_state_nxt  = S_IDLE;
                    w_sda_oe_nxt = 1'b0;
                end
            endcase
        end
    end

    assign sda_oe_o        = r_sda_oe;
    assign m_axis_tdata_o  = r_m_tdata;
    assign m_axis_tvalid_o = r_m_tvalid;
    assign m_axis_tuser_o  = r_m_tuser;
    assign s_axis_tready_o = r_s_tready;
    assign busy_o          = r_busy;
    assign err_o           = r_err;

endmodule
